cmp_tracker: RTL and testbench
==============================

# cmp_tracker

Parametrised compare-and-track block. Each valid cycle it compares operands `a` and `b` under a selectable relation and signedness, and registers the result with both operands. It also maintains a position index that advances while consecutive compares succeed, a lagging previous index, and run-length statistics. It sits between the operand datapath and the sort/selection control that consumes the index pair and hit flag.

## Interface
- `WIDTH`, 32: operand width in bits (≥2)
- `IDX_W`, 3: width of position indices
- `RUN_W`, 8: width of run-length counters
- `SIGNED`, 0: 1 = two's-complement compare, 0 = unsigned
---
- `clk` in 1: clock, all state on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `in_valid` in 1: operands/mode valid this cycle
- `mode` in 2: 00 GT (a>b), 01 GE, 10 LT, 11 EQ
- `clear` in 1: zero run statistics
- `a`, `b` in WIDTH: operands
- `out_valid` out 1: registered results valid
- `hit` out 1: registered compare result
- `d1`, `d2` out WIDTH: registered copies of `a`, `b`
- `cur_idx` out IDX_W: current position index
- `prev_idx` out IDX_W: previous position index
- `wrap` out 1: one-cycle pulse, `cur_idx` wrapped
- `run_len` out RUN_W: current consecutive-hit count
- `max_run` out RUN_W: largest `run_len` since reset/clear

## Operation
- Reset (`rst_n`=0 at edge): `out_valid`=0, `hit`=0, `d1`=`d2`=0, `cur_idx`=0, `prev_idx`=all ones, `wrap`=0, `run_len`=0, `max_run`=0. Reset overrides all inputs.
- `in_valid`=0: `out_valid`←0, `wrap`←0; all other outputs hold.
- `in_valid`=1, let h = relation(`a`,`b`,`mode`,`SIGNED`):
  - `out_valid`←1, `hit`←h, `d1`←`a`, `d2`←`b`.
  - h=1: `prev_idx`←`cur_idx`; `cur_idx`←`cur_idx`+1 mod 2^IDX_W; `wrap`←1 if old `cur_idx` was all ones, else 0.
  - h=0: `cur_idx`←0, `prev_idx`←all ones, `wrap`←0.
- Run statistics: base = `clear` ? 0 : `run_len`; baseMax = `clear` ? 0 : `max_run`.
  - h=1 with `in_valid`: `run_len`←base+1, saturating at 2^RUN_W−1.
  - h=0 with `in_valid`: `run_len`←0.
  - No `in_valid`: `run_len`←base.
  - `max_run`←max(baseMax, new `run_len`).
- `clear` never touches `cur_idx`, `prev_idx`, `hit`, `d1`, `d2`.
- `mode`/`SIGNED` apply per-cycle; `mode` changes mid-run are legal and take effect immediately.

## Timing
- Latency 1: results for inputs sampled at edge N appear after edge N, with `out_valid` high for exactly the cycles following valid input cycles.
- Throughput 1 compare/cycle; no backpressure.
- `wrap` is high only in the cycle following the wrapping input.
- Reset mid-run discards state; first post-reset valid input behaves as from fresh.
- Simultaneous `clear` and hit: statistics restart at 1, not 0.

## Structure
- Package `cmp_pkg`: mode encodings `CMP_GT`/`CMP_GE`/`CMP_LT`/`CMP_EQ` and the 2-bit mode type.
- Sub-module `cmp_core` (parameters WIDTH, SIGNED): purely combinational relation evaluator producing h. All registers live in `cmp_tracker`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → all outputs at reset values, `prev_idx`=3'b111.
- Unsigned GT run: `a`=5,`b`=3 for 9 valid cycles (IDX_W=3) → `cur_idx` 1..7,0,1; `prev_idx` 0..7,0; `wrap`=1 only after 8th input; `run_len`=9.
- Signed vs unsigned: `a`=32'hFFFF_FFFF,`b`=1, GT → `hit`=0 with SIGNED=1, `hit`=1 with SIGNED=0.
- Run break: 3 hits, then `a`=`b`=7 under GT → `hit`=0, `cur_idx`=0, `prev_idx`=7, `run_len`=0, `max_run`=3; same operands with EQ → `hit`=1.
- Clear collision: `max_run`=4, then `clear`=1 with a hitting input → `run_len`=1, `max_run`=1; `cur_idx` continues incrementing.
- Saturation/gaps: RUN_W=2, 6 consecutive hits with idle cycles interleaved → `run_len` stops at 3, `out_valid` low and state held in idle cycles.

Source files
------------

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - compare mode encodings shared by the tracker, its core and the interface
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_GT = 2'b00,
    CMP_GE = 2'b01,
    CMP_LT = 2'b10,
    CMP_EQ = 2'b11
  } cmp_mode_t;

endpackage

// File: rtl/cmp_tracker_if.sv
// rtl/cmp_tracker_if.sv - operand/result bundle between the datapath, the tracker and the sort control
interface cmp_tracker_if
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 3,
  parameter int RUN_W = 8
) ();

  logic             in_valid;
  cmp_mode_t        mode;
  logic             clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             hit;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] prev_idx;
  logic             wrap;
  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] max_run;

  modport master (
    output in_valid, mode, clear, a, b,
    input  out_valid, hit, d1, d2, cur_idx, prev_idx, wrap, run_len, max_run
  );

  modport slave (
    input  in_valid, mode, clear, a, b,
    output out_valid, hit, d1, d2, cur_idx, prev_idx, wrap, run_len, max_run
  );

endinterface

// File: rtl/cmp_core.sv
// rtl/cmp_core.sv - combinational relation evaluator for one operand pair
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  cmp_mode_t        i_mode,
  output logic             o_hit
);

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_FLIP = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_gt;
  logic             w_eq;

  assign w_a  = i_a ^ SIGN_FLIP;
  assign w_b  = i_b ^ SIGN_FLIP;
  assign w_gt = (w_a > w_b);
  assign w_eq = (i_a == i_b);

  always_comb begin
    o_hit = 1'b0;
    case (i_mode)
      CMP_GT:  o_hit = w_gt;
      CMP_GE:  o_hit = w_gt | w_eq;
      CMP_LT:  o_hit = ~w_gt & ~w_eq;
      CMP_EQ:  o_hit = w_eq;
      default: o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_tracker.sv
// rtl/cmp_tracker.sv - registered compare with hit-run position index and run-length statistics
module cmp_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IDX_W  = 3,
  parameter int RUN_W  = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  cmp_tracker_if.slave  bus
);

  localparam logic [IDX_W-1:0] IDX_ONES = '1;
  localparam logic [RUN_W-1:0] RUN_MAX  = '1;

  logic             w_hit;
  logic [RUN_W-1:0] w_base;
  logic [RUN_W-1:0] w_base_max;
  logic [RUN_W-1:0] w_run_next;
  logic [RUN_W-1:0] w_max_next;

  logic             r_out_valid;
  logic             r_hit;
  logic [WIDTH-1:0] r_d1;
  logic [WIDTH-1:0] r_d2;
  logic [IDX_W-1:0] r_cur_idx;
  logic [IDX_W-1:0] r_prev_idx;
  logic             r_wrap;
  logic [RUN_W-1:0] r_run_len;
  logic [RUN_W-1:0] r_max_run;

  cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .i_a    (bus.a),
    .i_b    (bus.b),
    .i_mode (bus.mode),
    .o_hit  (w_hit)
  );

  // clear only rebases the statistics, so a clear on a hit restarts the run at 1.
  assign w_base     = bus.clear ? '0 : r_run_len;
  assign w_base_max = bus.clear ? '0 : r_max_run;

  always_comb begin
    w_run_next = w_base;
    if (bus.in_valid) begin
      if (!w_hit)
        w_run_next = '0;
      else if (w_base != RUN_MAX)
        w_run_next = w_base + 1'b1;
    end
  end

  assign w_max_next = (w_run_next > w_base_max) ? w_run_next : w_base_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_cur_idx   <= '0;
      r_prev_idx  <= IDX_ONES;
      r_wrap      <= 1'b0;
      r_run_len   <= '0;
      r_max_run   <= '0;
    end else begin
      r_out_valid <= bus.in_valid;
      r_run_len   <= w_run_next;
      r_max_run   <= w_max_next;
      r_wrap      <= 1'b0;
      if (bus.in_valid) begin
        r_hit <= w_hit;
        r_d1  <= bus.a;
        r_d2  <= bus.b;
        if (w_hit) begin
          r_prev_idx <= r_cur_idx;
          r_cur_idx  <= r_cur_idx + 1'b1;
          r_wrap     <= (r_cur_idx == IDX_ONES);
        end else begin
          r_cur_idx  <= '0;
          r_prev_idx <= IDX_ONES;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.hit       = r_hit;
  assign bus.d1        = r_d1;
  assign bus.d2        = r_d2;
  assign bus.cur_idx   = r_cur_idx;
  assign bus.prev_idx  = r_prev_idx;
  assign bus.wrap      = r_wrap;
  assign bus.run_len   = r_run_len;
  assign bus.max_run   = r_max_run;

endmodule

// File: tb/tb_cmp_tracker.sv
// tb/tb_cmp_tracker.sv - directed bench: unsigned, signed and RUN_W=2 trackers driven in lockstep
module tb_cmp_tracker;
  import cmp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cmp_tracker_if #(.WIDTH(32), .IDX_W(3), .RUN_W(8)) bu ();
  cmp_tracker_if #(.WIDTH(32), .IDX_W(3), .RUN_W(8)) bs ();
  cmp_tracker_if #(.WIDTH(32), .IDX_W(3), .RUN_W(2)) br ();

  cmp_tracker #(.WIDTH(32), .IDX_W(3), .RUN_W(8), .SIGNED(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bu));
  cmp_tracker #(.WIDTH(32), .IDX_W(3), .RUN_W(8), .SIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
  cmp_tracker #(.WIDTH(32), .IDX_W(3), .RUN_W(2), .SIGNED(1'b0)) dut_r (.clk(clk), .rst_n(rst_n), .bus(br));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input cmp_mode_t m, input logic c,
                       input logic [31:0] a, input logic [31:0] b);
    bu.in_valid = v; bu.mode = m; bu.clear = c; bu.a = a; bu.b = b;
    bs.in_valid = v; bs.mode = m; bs.clear = c; bs.a = a; bs.b = b;
    br.in_valid = v; br.mode = m; br.clear = c; br.a = a; br.b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with valid hitting input present
    rst_n = 1'b0;
    drive(1'b1, CMP_GT, 1'b0, 32'd5, 32'd3);
    drive(1'b1, CMP_GT, 1'b0, 32'd5, 32'd3);
    chk("rst_out_valid", bu.out_valid, 0);
    chk("rst_hit",       bu.hit, 0);
    chk("rst_d1",        bu.d1, 0);
    chk("rst_d2",        bu.d2, 0);
    chk("rst_cur_idx",   bu.cur_idx, 0);
    chk("rst_prev_idx",  bu.prev_idx, 3'b111);
    chk("rst_wrap",      bu.wrap, 0);
    chk("rst_run_len",   bu.run_len, 0);
    chk("rst_max_run",   bu.max_run, 0);

    // Unsigned GT run of 9 hits: index wraps after the 8th
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, CMP_GT, 1'b0, 32'd5, 32'd3);
      chk($sformatf("run_ov_%0d", k),   bu.out_valid, 1);
      chk($sformatf("run_hit_%0d", k),  bu.hit, 1);
      chk($sformatf("run_cur_%0d", k),  bu.cur_idx, k % 8);
      chk($sformatf("run_prev_%0d", k), bu.prev_idx, (k - 1) % 8);
      chk($sformatf("run_wrap_%0d", k), bu.wrap, (k == 8) ? 1 : 0);
      chk($sformatf("run_len_%0d", k),  bu.run_len, k);
      chk($sformatf("run_sat_%0d", k),  br.run_len, (k > 3) ? 3 : k);
    end
    chk("run_d1", bu.d1, 5);
    chk("run_d2", bu.d2, 3);

    // Idle cycle holds state
    drive(1'b0, CMP_GT, 1'b0, 32'd0, 32'd9);
    chk("idle_ov",   bu.out_valid, 0);
    chk("idle_wrap", bu.wrap, 0);
    chk("idle_cur",  bu.cur_idx, 1);
    chk("idle_hit",  bu.hit, 1);
    chk("idle_d1",   bu.d1, 5);
    chk("idle_run",  bu.run_len, 9);
    chk("idle_max",  bu.max_run, 9);

    // Signedness: -1 > 1 only when unsigned
    drive(1'b1, CMP_GT, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("sgn_u_hit", bu.hit, 1);
    chk("sgn_s_hit", bs.hit, 0);
    chk("sgn_u_cur", bu.cur_idx, 2);
    chk("sgn_s_cur", bs.cur_idx, 0);
    chk("sgn_s_prv", bs.prev_idx, 7);
    chk("sgn_u_run", bu.run_len, 10);
    chk("sgn_s_run", bs.run_len, 0);
    chk("sgn_s_max", bs.max_run, 9);
    drive(1'b1, CMP_LT, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("sgn_lt_u", bu.hit, 0);
    chk("sgn_lt_s", bs.hit, 1);

    // Run break after 3 hits, then EQ on the same operands
    rst_n = 1'b0;
    drive(1'b0, CMP_GT, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    chk("rst2_run", bu.run_len, 0);
    chk("rst2_cur", bu.cur_idx, 0);
    for (int k = 0; k < 3; k++) drive(1'b1, CMP_GT, 1'b0, 32'd5, 32'd3);
    chk("brk_pre_cur", bu.cur_idx, 3);
    drive(1'b1, CMP_GT, 1'b0, 32'd7, 32'd7);
    chk("brk_hit",  bu.hit, 0);
    chk("brk_cur",  bu.cur_idx, 0);
    chk("brk_prev", bu.prev_idx, 7);
    chk("brk_run",  bu.run_len, 0);
    chk("brk_max",  bu.max_run, 3);
    chk("brk_d1",   bu.d1, 7);
    drive(1'b1, CMP_EQ, 1'b0, 32'd7, 32'd7);
    chk("eq_hit",  bu.hit, 1);
    chk("eq_cur",  bu.cur_idx, 1);
    chk("eq_prev", bu.prev_idx, 0);
    chk("eq_run",  bu.run_len, 1);
    chk("eq_max",  bu.max_run, 3);

    // Mode switches mid-run: GE on equal, LT, then build run to 4
    drive(1'b1, CMP_GE, 1'b0, 32'd9, 32'd9);
    chk("ge_hit", bu.hit, 1);
    drive(1'b1, CMP_LT, 1'b0, 32'd2, 32'd8);
    chk("lt_hit", bu.hit, 1);
    drive(1'b1, CMP_GT, 1'b0, 32'd8, 32'd2);
    chk("pre_clr_run", bu.run_len, 4);
    chk("pre_clr_max", bu.max_run, 4);
    chk("pre_clr_cur", bu.cur_idx, 4);

    // Clear colliding with a hit restarts statistics at 1
    drive(1'b1, CMP_GT, 1'b1, 32'd6, 32'd1);
    chk("clr_run",  bu.run_len, 1);
    chk("clr_max",  bu.max_run, 1);
    chk("clr_cur",  bu.cur_idx, 5);
    chk("clr_prev", bu.prev_idx, 4);
    chk("clr_d1",   bu.d1, 6);
    drive(1'b0, CMP_GT, 1'b1, 32'd0, 32'd0);
    chk("clr_idle_run", bu.run_len, 0);
    chk("clr_idle_max", bu.max_run, 0);
    chk("clr_idle_cur", bu.cur_idx, 5);
    chk("clr_idle_hit", bu.hit, 1);

    // RUN_W=2 saturation with idle cycles interleaved
    rst_n = 1'b0;
    drive(1'b0, CMP_GT, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, CMP_GT, 1'b0, 32'd4, 32'd1);
      chk($sformatf("sat_ov_%0d", k),  br.out_valid, 1);
      chk($sformatf("sat_run_%0d", k), br.run_len, (k > 3) ? 3 : k);
      drive(1'b0, CMP_LT, 1'b0, 32'd4, 32'd1);
      chk($sformatf("gap_ov_%0d", k),  br.out_valid, 0);
      chk($sformatf("gap_run_%0d", k), br.run_len, (k > 3) ? 3 : k);
      chk($sformatf("gap_cur_%0d", k), br.cur_idx, k);
      chk($sformatf("gap_hit_%0d", k), br.hit, 1);
    end
    chk("sat_max", br.max_run, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
